// File: rtl/external_memory_ctrl_if.sv
// Bus bundle for external_memory_ctrl: valid/ready data requests with their
// response, the combinational instruction fetch port, and the init status flag.
interface external_memory_ctrl_if #(
  parameter int ADDR_W = 10
);
  // A data request is accepted on a rising clock edge where req_valid and
  // req_ready are both high. req_write/req_size/req_addr/req_wdata must be
  // stable while req_valid is high. The response (rsp_valid pulse with
  // rsp_rdata/rsp_fault) appears in the cycle right after the accept edge and
  // is never backpressured.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic [ADDR_W-1:0] ifetch_addr;
  logic [15:0]       ifetch_data;
  logic              ifetch_fault;
  logic              init_busy;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, ifetch_addr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, ifetch_data,
           ifetch_fault, init_busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, ifetch_addr,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, ifetch_data,
           ifetch_fault, init_busy
  );
endinterface

// File: rtl/external_memory_ctrl.sv
// Byte-addressed unified memory: 1/2/4-byte little-endian data port with range
// faults, a forwarding 16-bit instruction fetch port, and a clear-after-reset sequencer.
module external_memory_ctrl #(
  parameter int          MEM_SIZE    = 49,
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  INIT_BYTE   = 8'h00,
  parameter logic [15:0] FAULT_INSTR = 16'hE800
) (
  input  logic                   clock,
  input  logic                   reset,
  external_memory_ctrl_if.slave  bus,
  output logic                   dbg_state_o
);
  localparam int AW1   = ADDR_W + 1;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic [31:0]       rsp_rdata_q;
  logic [7:0]        mem_q [MEM_SIZE];

  logic [AW1-1:0] base;
  logic [AW1-1:0] last;
  logic [AW1-1:0] byte_addr [4];
  logic [3:0]     be;
  logic           req_fault;
  logic           accept;
  logic           wr_fire;
  logic [31:0]    rd_data;
  logic [AW1-1:0] fa_lo;
  logic [AW1-1:0] fa_hi;
  logic           if_fault;
  logic [7:0]     if_lo;
  logic [7:0]     if_hi;

  function automatic logic [IDX_W-1:0] to_idx(input logic [AW1-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // Address math is one bit wider than the port so a request never wraps.
  always_comb begin
    base = {1'b0, bus.req_addr};
    be   = 4'b0000;
    last = base;
    case (bus.req_size)
      2'd0:    begin be = 4'b0001; last = base;                end
      2'd1:    begin be = 4'b0011; last = base + AW1'(1);      end
      2'd2:    begin be = 4'b1111; last = base + AW1'(3);      end
      default: begin be = 4'b0000; last = base;                end
    endcase
    req_fault = (bus.req_size == 2'd3) | (last >= AW1'(MEM_SIZE));
    accept    = bus.req_valid & ready_q;
    wr_fire   = accept & bus.req_write & ~req_fault;
    rd_data   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = base + AW1'(i);
      if (be[i] && !req_fault) rd_data[8*i +: 8] = mem_q[to_idx(byte_addr[i])];
    end
  end

  // Fetch sees the write landing at this edge so it never returns stale bytes.
  always_comb begin
    fa_lo    = {1'b0, bus.ifetch_addr};
    fa_hi    = fa_lo + AW1'(1);
    if_fault = busy_q | (fa_hi >= AW1'(MEM_SIZE));
    if_lo    = 8'h00;
    if_hi    = 8'h00;
    if (!if_fault) begin
      if_lo = mem_q[to_idx(fa_lo)];
      if_hi = mem_q[to_idx(fa_hi)];
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_fire && be[i]) begin
        if (byte_addr[i] == fa_lo) if_lo = bus.req_wdata[8*i +: 8];
        if (byte_addr[i] == fa_hi) if_hi = bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      mem_q[to_idx({1'b0, init_cnt_q})] <= INIT_BYTE;
    end else if (wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[to_idx(byte_addr[i])] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      rsp_valid_q <= accept;
      rsp_fault_q <= accept & req_fault;
      rsp_rdata_q <= (accept & ~bus.req_write & ~req_fault) ? rd_data : 32'h0;
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == ADDR_W'(MEM_SIZE - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.init_busy    = busy_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_fault    = rsp_fault_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.ifetch_fault = if_fault;
  assign bus.ifetch_data  = if_fault ? FAULT_INSTR : {if_hi, if_lo};
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_external_memory_ctrl.sv
// Bench for external_memory_ctrl: a byte-array model predicts every response,
// responses are popped from an expected queue as the DUT produces them.
module tb_external_memory_ctrl;
  logic clock;
  logic reset;
  logic dbg_state;

  external_memory_ctrl_if #(.ADDR_W(10)) bus();

  external_memory_ctrl #(
    .MEM_SIZE(49), .ADDR_W(10), .INIT_BYTE(8'h00), .FAULT_INSTR(16'hE800)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave),
    .dbg_state_o(dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  model [49];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Response scoreboard: {fault, rdata} popped on every rsp_valid pulse.
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (bus.rsp_valid === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rsp_unexpected: got fault=%b rdata=%h with no request pending",
                   bus.rsp_fault, bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rsp_fault, bus.rsp_rdata} !== e) begin
            tests_failed++;
            $display("FAIL rsp_data: got fault=%b rdata=%h, expected fault=%b rdata=%h",
                     bus.rsp_fault, bus.rsp_rdata, e[32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 49; i++) model[i] = 8'h00;
  endtask

  // Called at posedge+1; returns at posedge+1 with the response on the bus.
  task automatic send(input logic w, input logic [1:0] sz, input logic [9:0] a,
                      input logic [31:0] wd);
    int n;
    int last;
    logic f;
    logic [31:0] er;
    n    = 1 << sz;
    last = int'(a) + n - 1;
    f    = (sz == 2'd3) || (last >= 49);
    er   = 32'h0;
    for (int i = 0; i < 4; i++)
      if (i < n && !f && !w) er[8*i +: 8] = model[int'(a) + i];
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clock);
    exp_q.push_back({f, er});
    if (w && !f)
      for (int i = 0; i < n; i++) model[int'(a) + i] = wd[8*i +: 8];
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int cnt;
    logic bad_if;
    cnt    = 0;
    bad_if = 1'b0;
    while (bus.req_ready !== 1'b1 && cnt < 200) begin
      if (bus.ifetch_data !== 16'hE800 || bus.init_busy !== 1'b1) bad_if = 1'b1;
      @(posedge clock);
      #1;
      cnt++;
    end
    bus.req_valid = 1'b0;
    tests_run++;
    if (cnt !== 49) begin
      tests_failed++;
      $display("FAIL %s_init_len: ready after %0d cycles, expected 49", tag, cnt);
    end
    tests_run++;
    if (bad_if) begin
      tests_failed++;
      $display("FAIL %s_busy_fetch: ifetch_data/init_busy wrong during INIT, expected E800/1", tag);
    end
    tests_run++;
    if (bus.init_busy !== 1'b0 || dbg_state !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_run_state: busy=%b state=%b, expected 0/1", tag, bus.init_busy, dbg_state);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_size    = 2'd0;
    bus.req_addr    = 10'd0;
    bus.req_wdata   = 32'h0;
    bus.ifetch_addr = 10'd0;
    clear_model();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if ({bus.req_ready, bus.init_busy, bus.rsp_valid, bus.rsp_fault, dbg_state} !== 5'b01000
        || bus.rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b busy=%b rv=%b rf=%b st=%b rd=%h, expected 0 1 0 0 0 0",
               bus.req_ready, bus.init_busy, bus.rsp_valid, bus.rsp_fault, dbg_state, bus.rsp_rdata);
    end
    tests_run++;
    if (bus.ifetch_data !== 16'hE800 || bus.ifetch_fault !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_fetch: data=%h fault=%b, expected E800 1",
               bus.ifetch_data, bus.ifetch_fault);
    end
    wait_init("reset");
    tests_run++;
    if (bus.ifetch_data !== 16'h0000 || bus.ifetch_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_fetch: data=%h fault=%b, expected 0000 0", bus.ifetch_data, bus.ifetch_fault);
    end
  endtask

  task automatic test_rw();
    send(1'b1, 2'd2, 10'd4, 32'h44332211);
    send(1'b0, 2'd2, 10'd4, 32'h0);
    send(1'b0, 2'd0, 10'd6, 32'h0);
    send(1'b0, 2'd1, 10'd5, 32'h0);
  endtask

  task automatic test_fault();
    send(1'b1, 2'd1, 10'd46, 32'h0000B2A1);
    send(1'b1, 2'd0, 10'd48, 32'h000000C3);
    send(1'b1, 2'd2, 10'd46, 32'hDEADBEEF);
    send(1'b0, 2'd1, 10'd46, 32'h0);
    send(1'b0, 2'd0, 10'd48, 32'h0);
    send(1'b0, 2'd1, 10'd47, 32'h0);
    send(1'b0, 2'd3, 10'd0, 32'h0);
    send(1'b1, 2'd3, 10'd0, 32'hFFFFFFFF);
    send(1'b0, 2'd1, 10'd1023, 32'h0);
    send(1'b1, 2'd1, 10'd1023, 32'h00001234);
    send(1'b0, 2'd0, 10'd0, 32'h0);
  endtask

  task automatic test_ifetch();
    bus.ifetch_addr = 10'd10;
    #1;
    tests_run++;
    if (bus.ifetch_data !== {model[11], model[10]}) begin
      tests_failed++;
      $display("FAIL fetch_before: got %h, expected %h", bus.ifetch_data, {model[11], model[10]});
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd1;
    bus.req_addr  = 10'd10;
    bus.req_wdata = 32'h0000BEEF;
    #1;
    tests_run++;
    if (bus.ifetch_data !== 16'hBEEF || bus.ifetch_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_forward: got %h fault=%b, expected BEEF 0", bus.ifetch_data, bus.ifetch_fault);
    end
    @(posedge clock);
    exp_q.push_back({1'b0, 32'h0});
    model[10] = 8'hEF;
    model[11] = 8'hBE;
    #1;
    bus.req_valid = 1'b0;
    tests_run++;
    if (bus.ifetch_data !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL fetch_after: got %h, expected BEEF", bus.ifetch_data);
    end
    bus.ifetch_addr = 10'd48;
    #1;
    tests_run++;
    if (bus.ifetch_fault !== 1'b1 || bus.ifetch_data !== 16'hE800) begin
      tests_failed++;
      $display("FAIL fetch_range: fault=%b data=%h, expected 1 E800", bus.ifetch_fault, bus.ifetch_data);
    end
    bus.ifetch_addr = 10'd47;
    #1;
    tests_run++;
    if (bus.ifetch_fault !== 1'b0 || bus.ifetch_data !== {model[48], model[47]}) begin
      tests_failed++;
      $display("FAIL fetch_edge: fault=%b data=%h, expected 0 %h",
               bus.ifetch_fault, bus.ifetch_data, {model[48], model[47]});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0;
    logic [31:0] d1;
    logic        seen [4];
    d0 = $urandom();
    d1 = 32'($urandom_range(0, 255));
    send(1'b1, 2'd2, 10'd20, d0);
    seen[0] = bus.rsp_valid;
    send(1'b0, 2'd2, 10'd20, 32'h0);
    seen[1] = bus.rsp_valid;
    send(1'b1, 2'd0, 10'd30, d1);
    seen[2] = bus.rsp_valid;
    send(1'b0, 2'd1, 10'd29, 32'h0);
    seen[3] = bus.rsp_valid;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (seen[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_valid%0d: rsp_valid=%b, expected 1", i, seen[i]);
      end
    end
    @(posedge clock);
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_valid: rsp_valid=%b, expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 10'd4;
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b0 || bus.init_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_state: ready=%b busy=%b, expected 0 1", bus.req_ready, bus.init_busy);
    end
    @(posedge clock);
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_rsp: rsp_valid=%b, expected 0", bus.rsp_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    clear_model();
    wait_init("midrst");
    bus.ifetch_addr = 10'd10;
    #1;
    tests_run++;
    if (bus.ifetch_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midrst_fetch: got %h, expected 0000", bus.ifetch_data);
    end
    send(1'b0, 2'd2, 10'd4, 32'h0);
    send(1'b0, 2'd2, 10'd20, 32'h0);
    send(1'b0, 2'd2, 10'd45, 32'h0);
  endtask

  task automatic test_drain();
    @(posedge clock);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d responses never arrived, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_fault();
    test_ifetch();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
